// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end for a 256 x 32 data memory.
// Unaligned accesses that span two words are split into two word accesses.
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic [ADDR_W-3:0] dm_adr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [31:0]       dm_dout,
  output logic [1:0]        o_dbg_state
);

  // Handshake: req is sampled only in IDLE (busy=0); busy stays high until
  // the DONE cycle ends, and ready pulses high for exactly that DONE cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, DONE = 2'd3} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_sign;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_asm;
  logic [31:0]         r_rdata;

  logic [1:0]          w_off;
  logic [2:0]          w_nbytes;
  logic [2:0]          w_room;
  logic [2:0]          w_n0;
  logic [2:0]          w_n1;
  logic                w_cross;
  logic                w_acc;
  logic [ADDR_W-3:0]   w_wadr;
  logic [31:0]         w_asm_next;
  logic [31:0]         w_din;
  logic [31:0]         w_ld_ext;

  assign w_off    = r_addr[1:0];
  assign w_nbytes = (r_size == 2'b00) ? 3'd1 : (r_size == 2'b01) ? 3'd2 : 3'd4;
  assign w_room   = 3'd4 - {1'b0, w_off};
  assign w_n0     = (w_nbytes < w_room) ? w_nbytes : w_room;
  assign w_n1     = w_nbytes - w_n0;
  assign w_cross  = ({1'b0, w_off} + w_nbytes) > 3'd4;
  assign w_acc    = (r_state == ACC0) || (r_state == ACC1);
  assign w_wadr   = r_addr[ADDR_W-1:2];

  // Memory byte k maps to assembly lane (k-off) in ACC0 and lane (n0+k) in ACC1.
  always_comb begin
    int         off_i;
    int         n0_i;
    int         n1_i;
    int         lane;
    logic       hit;
    logic [1:0] lane2;
    w_asm_next = r_asm;
    w_din      = dm_dout;
    off_i      = int'(w_off);
    n0_i       = int'(w_n0);
    n1_i       = int'(w_n1);
    lane       = 0;
    hit        = 1'b0;
    lane2      = 2'b00;
    for (int k = 0; k < 4; k++) begin
      hit  = 1'b0;
      lane = 0;
      if (r_state == ACC0) begin
        hit  = (k >= off_i) && (k < off_i + n0_i);
        lane = k - off_i;
      end else if (r_state == ACC1) begin
        hit  = (k < n1_i);
        lane = n0_i + k;
      end
      lane2 = 2'(lane);
      if (hit) begin
        w_asm_next[{lane2, 3'b000} +: 8] = dm_dout[8*k +: 8];
        w_din[8*k +: 8]                  = r_wdata[{lane2, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    w_ld_ext = w_asm_next;
    if (r_size == 2'b00)
      w_ld_ext = {{24{r_sign & w_asm_next[7]}}, w_asm_next[7:0]};
    else if (r_size == 2'b01)
      w_ld_ext = {{16{r_sign & w_asm_next[15]}}, w_asm_next[15:0]};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req) w_next = ACC0;
      ACC0:    w_next = w_cross ? ACC1 : DONE;
      ACC1:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != IDLE);
    ready  = (r_state == DONE);
    dm_re  = w_acc;
    dm_we  = w_acc && r_we;
    dm_din = (w_acc && r_we) ? w_din : 32'd0;
    dm_adr = '0;
    if (r_state == ACC0)      dm_adr = w_wadr;
    else if (r_state == ACC1) dm_adr = w_wadr + {{(ADDR_W-3){1'b0}}, 1'b1};
  end

  assign rdata       = r_rdata;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_asm   <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req) begin
        r_we    <= we;
        r_size  <= size;
        r_sign  <= sign_ext;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_asm   <= 32'd0;
      end
      if (w_acc) r_asm <= w_asm_next;
      if (w_acc && w_next == DONE && !r_we) r_rdata <= w_ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus multi-cycle corner sequences,
// with a behavioural 256-word memory attached to the data memory port.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, ready, dm_we, dm_re;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [7:0]  dm_adr;
  logic [1:0]  dbg_state;

  logic [31:0] mem [256];
  logic        preload_go = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .ready(ready), .rdata(rdata),
    .dm_adr(dm_adr), .dm_din(dm_din), .dm_we(dm_we), .dm_re(dm_re),
    .dm_dout(dm_dout), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign dm_dout = mem[dm_adr];

  always @(posedge clk) begin
    if (preload_go) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[0]   <= 32'h44332211;
      mem[1]   <= 32'h88776655;
      mem[255] <= 32'hDEADBEEF;
    end else if (dm_we) begin
      mem[dm_adr] <= dm_din;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sx;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nwe;
    logic [7:0]  exp_a0;
    logic [7:0]  exp_a1;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    logic [31:0] exp_w255;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload();
    preload_go = 1'b1;
    @(posedge clk); #1;
    preload_go = 1'b0;
  endtask

  // Drive a request from IDLE; returns one time unit after the accept edge.
  task automatic issue(input logic w, input logic [1:0] s, input logic sx,
                       input logic [9:0] a, input logic [31:0] d);
    we = w; size = s; sign_ext = sx; addr = a; wdata = d;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    int         lat, nre, nwe, npulse;
    logic [7:0] a0, a1;

    vecs[0] = '{1'b0, 2'b10, 1'b0, 10'h004, 32'h0, 32'h88776655, 2, 0, 8'd1, 8'd0, 32'h44332211, 32'h88776655, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 2'b00, 1'b1, 10'h007, 32'h0, 32'hFFFFFF88, 2, 0, 8'd1, 8'd0, 32'h44332211, 32'h88776655, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 2'b00, 1'b0, 10'h007, 32'h0, 32'h00000088, 2, 0, 8'd1, 8'd0, 32'h44332211, 32'h88776655, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 2'b01, 1'b0, 10'h003, 32'h0, 32'h00005544, 3, 0, 8'd0, 8'd1, 32'h44332211, 32'h88776655, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 2'b10, 1'b0, 10'h002, 32'hAABBCCDD, 32'h00005544, 3, 2, 8'd0, 8'd1, 32'hCCDD2211, 32'h8877AABB, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 2'b10, 1'b0, 10'h3FE, 32'h0, 32'h2211DEAD, 3, 0, 8'd255, 8'd0, 32'h44332211, 32'h88776655, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 2'b11, 1'b0, 10'h004, 32'h0, 32'h88776655, 2, 0, 8'd1, 8'd0, 32'h44332211, 32'h88776655, 32'hDEADBEEF};
    vecs[7] = '{1'b0, 2'b01, 1'b1, 10'h006, 32'h0, 32'hFFFF8877, 2, 0, 8'd1, 8'd0, 32'h44332211, 32'h88776655, 32'hDEADBEEF};
    vecs[8] = '{1'b1, 2'b00, 1'b0, 10'h005, 32'h123456EE, 32'hFFFF8877, 2, 1, 8'd1, 8'd0, 32'h44332211, 32'h8877EE55, 32'hDEADBEEF};
    vecs[9] = '{1'b1, 2'b01, 1'b0, 10'h3FF, 32'h0000A1B2, 32'hFFFF8877, 3, 2, 8'd255, 8'd0, 32'h443322A1, 32'h88776655, 32'hB2ADBEEF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   {31'd0, busy},  32'd0);
    chk("rst_ready",  {31'd0, ready}, 32'd0);
    chk("rst_rdata",  rdata,          32'd0);
    chk("rst_dm_we",  {31'd0, dm_we}, 32'd0);
    chk("rst_dm_re",  {31'd0, dm_re}, 32'd0);
    chk("rst_dm_adr", {24'd0, dm_adr}, 32'd0);
    chk("rst_dm_din", dm_din,         32'd0);
    chk("rst_state",  {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      preload();
      issue(vecs[v].we, vecs[v].size, vecs[v].sx, vecs[v].addr, vecs[v].wdata);
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd1);
      lat = 1; nre = 0; nwe = 0; a0 = '0; a1 = '0;
      while (!ready && lat < 8) begin
        if (dm_re) begin
          if (nre == 0) a0 = dm_adr;
          else if (nre == 1) a1 = dm_adr;
          nre++;
        end
        if (dm_we) nwe++;
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      chk($sformatf("v%0d_ready_busy", v), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
      chk($sformatf("v%0d_nre", v), nre, vecs[v].exp_lat - 1);
      chk($sformatf("v%0d_nwe", v), nwe, vecs[v].exp_nwe);
      chk($sformatf("v%0d_adr0", v), {24'd0, a0}, {24'd0, vecs[v].exp_a0});
      if (vecs[v].exp_lat == 3)
        chk($sformatf("v%0d_adr1", v), {24'd0, a1}, {24'd0, vecs[v].exp_a1});
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_pulse", v), {31'd0, ready}, 32'd0);
      chk($sformatf("v%0d_idle_busy", v), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_idle_adr", v), {24'd0, dm_adr}, 32'd0);
      chk($sformatf("v%0d_rdata_hold", v), rdata, vecs[v].exp_rdata);
      chk($sformatf("v%0d_word0", v), mem[0], vecs[v].exp_w0);
      chk($sformatf("v%0d_word1", v), mem[1], vecs[v].exp_w1);
      chk($sformatf("v%0d_word255", v), mem[255], vecs[v].exp_w255);
    end

    // Re-pulsed req while busy on a crossing store must be ignored
    preload();
    issue(1'b1, 2'b10, 1'b0, 10'h002, 32'hAABBCCDD);
    addr = 10'h004; we = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    npulse = 0;
    for (int c = 0; c < 8; c++) begin
      if (ready) npulse++;
      @(posedge clk); #1;
    end
    chk("ignore_ready_pulses", npulse, 1);
    chk("ignore_busy_end", {31'd0, busy}, 32'd0);
    chk("ignore_word0", mem[0], 32'hCCDD2211);
    chk("ignore_word1", mem[1], 32'h8877AABB);
    chk("ignore_rdata", rdata, 32'hFFFF8877);

    // Reset during ACC1 of a crossing store
    preload();
    issue(1'b1, 2'b10, 1'b0, 10'h002, 32'hAABBCCDD);
    @(posedge clk); #1;
    chk("ra_in_acc1", {30'd0, dbg_state}, 32'd2);
    rst = 1'b1;
    #1;
    chk("ra_busy",  {31'd0, busy},  32'd0);
    chk("ra_ready", {31'd0, ready}, 32'd0);
    chk("ra_rdata", rdata,          32'd0);
    chk("ra_dm_we", {31'd0, dm_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ra_word0", mem[0], 32'hCCDD2211);
    chk("ra_word1", mem[1], 32'h88776655);
    chk("ra_idle",  {30'd0, dbg_state}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the CPU memory stage and the 256 x 32-bit word data memory, directly upstream of it.
- Converts byte-addressed load/store requests (byte, half, word; aligned or unaligned) into word accesses on the data memory port.
- Sub-word stores are done as a read-merge-write inside one access cycle.
- An access that crosses a word boundary becomes two sequential word accesses; the CPU waits on `busy`/`ready` for the result.

Parameters:
- ADDR_W, 10, byte-address width. The word address is ADDR_W-2 = 8 bits and matches the 256-word memory.
- DATA_W is fixed at 32 and is not a parameter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request; sampled only when busy=0
- we  in  1  1=store, 0=load
- size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
- sign_ext  in  1  loads only: sign-extend byte/half result
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-justified
- busy  out  1  request accepted and not yet complete
- ready  out  1  one-cycle completion pulse
- rdata  out  32  load result, registered
- dm_adr  out  8  word address to data memory
- dm_din  out  32  write word to data memory
- dm_we  out  1  data memory write enable
- dm_re  out  1  data memory read enable
- dm_dout  in  32  data memory read word (combinational read)

Behaviour:
- Reset: all outputs and internal registers go to zero immediately when rst=1, asynchronously.
  - state=IDLE; busy=0, ready=0, rdata=0, dm_we=0, dm_re=0, dm_adr=0, dm_din=0.
- Byte lanes are little-endian: byte offset k maps to word bits [8k+7:8k].
- FSM states: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - If req=1 at a rising edge, latch we, size, sign_ext, addr and wdata, then go to ACC0.
  - busy=1 from the next cycle onward.
- ACC0:
  - dm_adr=addr[ADDR_W-1:2]; dm_re=1.
  - Bytes in this word: n0 = min(nbytes, 4-off), where off=addr[1:0] and nbytes=1/2/4.
  - Load: capture bytes off..off+n0-1 of dm_dout into assembly lanes 0..n0-1.
  - Store: dm_we=1. dm_din = dm_dout with bytes off..off+n0-1 replaced by wdata lanes 0..n0-1. Other bytes pass through unchanged.
  - Next state: ACC1 if off+nbytes>4, otherwise DONE.
- ACC1:
  - dm_adr = word address + 1, wrapping 255 -> 0.
  - Handles the remaining n1 = nbytes-n0 bytes at offsets 0..n1-1, mapped to lanes n0..nbytes-1.
  - Same load/store rules as ACC0. Next state: DONE.
- DONE:
  - ready=1 for exactly one cycle; busy stays 1 during DONE; next state IDLE.
  - Load: rdata is updated at the edge entering DONE. Zero- or sign-extended from bit 7 (byte) or bit 15 (half) according to sign_ext.
  - Store: rdata is unchanged.
- Latency after the accept edge:
  - Non-crossing access: ACC0 then DONE, so ready is high in the 2nd cycle.
  - Crossing access: ready is high in the 3rd cycle.
- rdata holds its value until the next load completes.
- dm_we and dm_re are 0 in IDLE and DONE; dm_adr and dm_din are 0 in IDLE.
- req while busy=1, including in DONE, is ignored. The requester must hold req until it sees busy.
- Back-to-back: a new req can be accepted on the edge that leaves DONE is not allowed; acceptance happens only from IDLE. Minimum spacing is 3 cycles.
- Reset during ACC1 of a crossing store: the first word stays written and the second word is not written. The partial store is architecturally accepted.
- size=11 behaves identically to size=10.

Test Plan:
- Memory preload for all scenarios: word0=0x44332211, word1=0x88776655, word255=0xDEADBEEF.
- Load word, addr=0x004, we=0:
  - rdata=0x88776655.
  - ready high exactly 2 cycles after the accept edge.
  - dm_we never asserted.
- Load byte, addr=0x007:
  - sign_ext=1 -> rdata=0xFFFFFF88.
  - sign_ext=0 -> rdata=0x00000088.
  - Words 0 and 1 are unchanged.
- Crossing half load, addr=0x003, sign_ext=0:
  - dm_adr=0 then 1.
  - rdata=0x00005544.
  - ready 3 cycles after accept.
- Crossing word store, addr=0x002, wdata=0xAABBCCDD:
  - word0=0xCCDD2211, word1=0x8877AABB.
  - dm_we high in both ACC cycles.
- Wrap-around word load, addr=0x3FE:
  - dm_adr=255 then 0.
  - rdata=0x2211DEAD.
- Interruptions during a crossing store, addr=0x002:
  - Pulse req again while busy=1: it is ignored and there is exactly one ready pulse.
  - Repeat the store and assert rst during ACC1: busy=0, ready=0 and rdata=0 immediately; word1 stays 0x88776655.
